seg7_scan_mux: RTL and testbench

//   Parametrised, time-multiplexed seven-segment display driver with source selection.

---
 rtl/seg7_scan_mux.sv | 209 ++++++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment driver: selects a binary source, converts it to BCD
// with a bit-serial double-dabble engine, and scans the digits over one shared segment bus.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module seg7_scan_mux #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_W     = 14,
  parameter int NUM_DIGITS = 5,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_SRC*DATA_W-1:0]                    src_data,
  input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] src_sel,
  input  logic                                         load,
  output logic [6:0]                                   seg,
  output logic [NUM_DIGITS-1:0]                        an,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         ovf
);

  localparam int BCD_NIB = (DATA_W * 302 + 999) / 1000 + 1;
  localparam int ACC_NIB = (BCD_NIB > NUM_DIGITS) ? BCD_NIB : NUM_DIGITS;
  localparam int ACC_W   = ACC_NIB * 4;
  localparam int DIG_W   = NUM_DIGITS * 4;
  localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W   = $clog2(SCAN_DIV);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [ACC_W-1:0] dd_adjust(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < ACC_NIB; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic hi_nonzero(input logic [ACC_W-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = DIG_W; i < ACC_W; i++) r = r | a[i];
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W-1:0]    acc_step;
  logic [DATA_W-1:0]   sel_word;
  logic [DIG_W-1:0]    digits_q;
  logic                ovf_q;
  logic                done_q;
  logic                busy_c;
  logic                finish;
  logic                last_step;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          nib_sel;
  logic                blank_sel;

  always_comb begin
    sel_word = src_data[DATA_W-1:0];
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(src_sel) == k) sel_word = src_data[k*DATA_W +: DATA_W];
    end
  end

  assign last_step = (cnt_q == CNT_W'(DATA_W - 1));
  assign acc_adj   = dd_adjust(acc_q);
  assign acc_step  = (acc_adj << 1) | ACC_W'(shift_q[DATA_W-1]);

  // Conversion control FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // A load always (re)starts a conversion, even mid-flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load) state_d = S_CONV;
      S_CONV: begin
        if (load)           state_d = S_CONV;
        else if (last_step) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state_q == S_CONV);
    finish = busy_c && !load && last_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (busy_c) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shift_q <= sel_word;
      acc_q   <= '0;
    end else if (busy_c) begin
      shift_q <= shift_q << 1;
      acc_q   <= acc_step;
    end
  end

  // The final step's result goes straight to the display registers, so partial
  // BCD values are never visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        digits_q <= acc_step[DIG_W-1:0];
        ovf_q    <= hi_nonzero(acc_step);
      end
    end
  end

  always_comb begin
    pre_d = (pre_q == PRE_W'(SCAN_DIV - 1)) ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    nib_sel   = digits_q[3:0];
    blank_sel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib_sel = digits_q[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank_sel = (k != 0) && ((digits_q >> (4*k)) == '0);
`endif
      end
    end
    an_d = ~(NUM_DIGITS'(1) << idx_d);
    if (ovf_q)          seg_d = SEG_DASH;
    else if (blank_sel) seg_d = SEG_BLANK;
    else                seg_d = seg_encode(nib_sel);
  end

  // Anode and segment registers load from the same next index, keeping them paired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= ~NUM_DIGITS'(1);
      seg_q <= SEG_ZERO;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_c;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: a 5-digit and a 4-digit instance share stimulus.
module tb_seg7_scan_mux;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S8 = 7'b0000000, SD = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst = 1'b1;
  logic [27:0] src_data = '0;
  logic        src_sel = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg5, seg4;
  logic [4:0]  an5;
  logic [3:0]  an4;
  logic        busy5, done5, ovf5, busy4, done4, ovf4;
  int          checks = 0;
  int          errors = 0;

  always #5 if (clk_en) clk = ~clk;

  seg7_scan_mux #(.NUM_SRC(2), .DATA_W(14), .NUM_DIGITS(5), .SCAN_DIV(4)) dut5 (
    .clk(clk), .rst(rst), .src_data(src_data), .src_sel(src_sel), .load(load),
    .seg(seg5), .an(an5), .busy(busy5), .done(done5), .ovf(ovf5));

  seg7_scan_mux #(.NUM_SRC(2), .DATA_W(14), .NUM_DIGITS(4), .SCAN_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .src_data(src_data), .src_sel(src_sel), .load(load),
    .seg(seg4), .an(an4), .busy(busy4), .done(done4), .ovf(ovf4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [13:0] v, input logic s);
    if (s) src_data[27:14] = v;
    else   src_data[13:0]  = v;
    src_sel = s;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done5) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic capture5(output logic [34:0] segs, output bit ok);
    logic [4:0] seen;
    seen = '0;
    segs = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int k = 0; k < 5; k++) begin
        if (an5 == ~(5'b00001 << k)) begin
          segs[7*k +: 7] = seg5;
          seen[k] = 1'b1;
        end
      end
    end
    ok = &seen;
  endtask

  task automatic capture4(output logic [27:0] segs, output bit ok);
    logic [3:0] seen;
    seen = '0;
    segs = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (an4 == ~(4'b0001 << k)) begin
          segs[7*k +: 7] = seg4;
          seen[k] = 1'b1;
        end
      end
    end
    ok = &seen;
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++; if (an5 !== 5'b11110) begin errors++; $display("FAIL reset_an5 got %b exp %b", an5, 5'b11110); end
    checks++; if (seg5 !== S0) begin errors++; $display("FAIL reset_seg5 got %b exp %b", seg5, S0); end
    checks++; if ({busy5, done5, ovf5} !== 3'b000) begin errors++; $display("FAIL reset_flags5 got %b exp 000", {busy5, done5, ovf5}); end
    checks++; if (an4 !== 4'b1110) begin errors++; $display("FAIL reset_an4 got %b exp 1110", an4); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_convert;
    logic [34:0] s5;
    logic [27:0] s4;
    bit ok;
    do_load(14'h1555, 1'b0);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if ({busy5, done5} !== 2'b10) begin errors++; $display("FAIL conv_busy cycle %0d got busy/done %b exp 10", i, {busy5, done5}); end
      tick();
    end
    checks++; if ({busy5, done5} !== 2'b01) begin errors++; $display("FAIL conv_done got busy/done %b exp 01", {busy5, done5}); end
    tick();
    checks++; if (done5 !== 1'b0) begin errors++; $display("FAIL conv_done_width got %b exp 0", done5); end
    capture5(s5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL conv_scan5 not every digit enabled"); end
    checks++; if (s5 !== {LZ, S5, S4, S6, S1}) begin errors++; $display("FAIL conv_disp5 got %h exp %h", s5, {LZ, S5, S4, S6, S1}); end
    capture4(s4, ok);
    checks++; if (s4 !== {S5, S4, S6, S1} || ovf4 !== 1'b0) begin errors++; $display("FAIL conv_disp4 got %h ovf %b exp %h ovf 0", s4, ovf4, {S5, S4, S6, S1}); end
  endtask

  task automatic test_async_reset;
    do_load(14'h3FFF, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    clk_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (an5 !== 5'b11110 || seg5 !== S0) begin errors++; $display("FAIL areset_disp got an %b seg %b exp 11110 %b", an5, seg5, S0); end
    checks++; if ({busy5, done5, ovf5} !== 3'b000) begin errors++; $display("FAIL areset_flags got %b exp 000", {busy5, done5, ovf5}); end
    #5;
    rst = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy5 || done5) break;
    end
    checks++; if ({busy5, done5} !== 2'b00) begin errors++; $display("FAIL areset_abort got busy/done %b exp 00", {busy5, done5}); end
  endtask

  task automatic test_scan;
    logic [34:0] s5;
    logic [27:0] s4;
    logic [4:0]  prev;
    bit ok;
    bit got;
    int start;
    do_load(14'h3FFF, 1'b1);
    wait_done(got);
    checks++; if (!got) begin errors++; $display("FAIL scan_done_timeout got no done exp done"); end
    checks++; if (ovf5 !== 1'b0 || ovf4 !== 1'b1) begin errors++; $display("FAIL scan_ovf got %b%b exp 01", ovf5, ovf4); end
    tick();
    capture5(s5, ok);
    checks++; if (!ok || s5 !== {S1, S6, S3, S8, S3}) begin errors++; $display("FAIL scan_disp5 got %h exp %h", s5, {S1, S6, S3, S8, S3}); end
    capture4(s4, ok);
    checks++; if (!ok || s4 !== {SD, SD, SD, SD}) begin errors++; $display("FAIL scan_dash4 got %h exp %h", s4, {SD, SD, SD, SD}); end
    prev = an5;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (an5 != prev) break;
    end
    start = -1;
    for (int k = 0; k < 5; k++) if (an5 == ~(5'b00001 << k)) start = k;
    checks++; if (start < 0) begin errors++; $display("FAIL scan_onehot got %b exp one-hot-low", an5); start = 0; end
    for (int j = 0; j < 24; j++) begin
      checks++;
      if (an5 !== ~(5'b00001 << ((start + j / 4) % 5))) begin
        errors++;
        $display("FAIL scan_seq step %0d got %b exp %b", j, an5, ~(5'b00001 << ((start + j / 4) % 5)));
      end
      tick();
    end
  endtask

  task automatic test_restart;
    logic [34:0] s5;
    bit ok;
    int ndone;
    ndone = 0;
    do_load(14'h1555, 1'b0);
    src_data[27:14] = 14'h3FFF;
    for (int k = 0; k < 26; k++) begin
      if (done5) ndone++;
      checks++;
      if (done5 !== (k == 20)) begin errors++; $display("FAIL restart_done k=%0d got %b exp %b", k, done5, (k == 20)); end
      if (k == 5) begin
        src_sel = 1'b1;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL restart_pulses got %0d exp 1", ndone); end
    capture5(s5, ok);
    checks++; if (!ok || s5 !== {S1, S6, S3, S8, S3}) begin errors++; $display("FAIL restart_disp got %h exp %h", s5, {S1, S6, S3, S8, S3}); end
  endtask

  task automatic test_zero;
    logic [34:0] s5;
    bit ok;
    bit got;
    do_load(14'd0, 1'b0);
    wait_done(got);
    checks++; if (!got || ovf5 !== 1'b0) begin errors++; $display("FAIL zero_done got done %b ovf %b exp 1 0", got, ovf5); end
    tick();
    capture5(s5, ok);
    checks++; if (!ok || s5 !== {LZ, LZ, LZ, LZ, S0}) begin errors++; $display("FAIL zero_disp got %h exp %h", s5, {LZ, LZ, LZ, LZ, S0}); end
  endtask

  task automatic test_back_to_back;
    logic [34:0] s5;
    logic [27:0] s4;
    bit ok;
    bit got;
    int n;
    do_load(14'd0, 1'b0);
    wait_done(got);
    checks++; if (!got) begin errors++; $display("FAIL b2b_first_done got none exp done"); end
    do_load(14'd42, 1'b0);
    checks++; if (busy5 !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b exp 1", busy5); end
    n = 0;
    while (!done5 && n < 30) begin
      tick();
      n++;
    end
    checks++; if (n != 14) begin errors++; $display("FAIL b2b_latency got %0d exp 14", n); end
    tick();
    capture5(s5, ok);
    checks++; if (!ok || s5 !== {LZ, LZ, LZ, S4, S2}) begin errors++; $display("FAIL b2b_disp5 got %h exp %h", s5, {LZ, LZ, LZ, S4, S2}); end
    capture4(s4, ok);
    checks++; if (!ok || s4 !== {LZ, LZ, S4, S2} || ovf4 !== 1'b0) begin errors++; $display("FAIL b2b_disp4 got %h ovf %b exp %h ovf 0", s4, ovf4, {LZ, LZ, S4, S2}); end
  endtask

  task automatic test_no_load;
    logic [34:0] s5;
    bit ok;
    int seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      src_data = 28'hABC_DEF0 ^ 28'(i * 1234567);
      src_sel = i[0];
      tick();
      if (busy5 || done5) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL noload_activity got %0d exp 0", seen); end
    capture5(s5, ok);
    checks++; if (!ok || s5 !== {LZ, LZ, LZ, S4, S2}) begin errors++; $display("FAIL noload_disp got %h exp %h", s5, {LZ, LZ, LZ, S4, S2}); end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_async_reset();
    test_scan();
    test_restart();
    test_zero();
    test_back_to_back();
    test_no_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
